// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: bundles the requester-side and downstream AXI read signals of the arbiter.
//   slave  : arbiter view (drives s_arready/s_r*, m_axi_ar*, m_axi_rready)
//   master : environment view (requesters and memory-side port)
interface axi_rd_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              s_arvalid;
  logic [1:0]              s_arready;
  logic [2*ADDR_WIDTH-1:0] s_araddr;
  logic [2*ID_WIDTH-1:0]   s_arid;
  logic [15:0]             s_arlen;
  logic [5:0]              s_arsize;
  logic [3:0]              s_arburst;
  logic [1:0]              s_rvalid;
  logic [1:0]              s_rready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rlast;
  logic [ID_WIDTH-1:0]     s_rid;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic [ID_WIDTH-1:0]     m_axi_rid;
  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    output m_axi_arvalid, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_rready
  );
  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI read port between icache (0) and dcache (1).
//   clk, reset   : clock, synchronous active-high reset
//   bus          : requester AR/R channels and downstream AR/R channels (slave modport)
//   protocol_err : sticky flag for rid mismatch or rlast/length disagreement
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  axi_rd_arbiter_if.slave   bus,
  output logic              protocol_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                r_state, w_next;
  logic                  r_owner, r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len, r_beat_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  w_win, w_data, w_beat, w_req, w_acc;
  logic [1:0]            w_oh;
  // on a tie the requester that did not win last time goes first
  assign w_win  = (bus.s_arvalid == 2'b11) ? ~r_last_grant : bus.s_arvalid[1];
  assign w_req  = (r_state == IDLE) & |bus.s_arvalid;
  assign w_acc  = (r_state == ADDR) & bus.m_axi_arready;
  assign w_data = r_state == DATA;
  assign w_oh   = {r_owner, ~r_owner};
  assign w_beat = w_data & bus.m_axi_rvalid & bus.s_rready[r_owner];
  assign bus.m_axi_arvalid = r_state == ADDR;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arid    = r_id;
  assign bus.m_axi_arlen   = r_len;
  assign bus.m_axi_arsize  = r_size;
  assign bus.m_axi_arburst = r_burst;
  assign bus.s_arready     = w_acc ? w_oh : 2'b00;
  assign bus.m_axi_rready  = w_data & bus.s_rready[r_owner];
  assign bus.s_rvalid      = (w_data & bus.m_axi_rvalid) ? w_oh : 2'b00;
  assign bus.s_rdata       = w_data ? bus.m_axi_rdata : '0;
  assign bus.s_rresp       = w_data ? bus.m_axi_rresp : '0;
  assign bus.s_rlast       = w_data & bus.m_axi_rlast;
  assign bus.s_rid         = w_data ? bus.m_axi_rid : '0;
  assign protocol_err      = r_err;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? ADDR : IDLE;
      ADDR:    w_next = w_acc ? DATA : ADDR;
      DATA:    w_next = (w_beat & bus.m_axi_rlast) ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_id         <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_req) begin
        r_owner <= w_win;
        r_addr  <= w_win ? bus.s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.s_araddr[ADDR_WIDTH-1:0];
        r_id    <= w_win ? bus.s_arid[2*ID_WIDTH-1:ID_WIDTH] : bus.s_arid[ID_WIDTH-1:0];
        r_len   <= w_win ? bus.s_arlen[15:8] : bus.s_arlen[7:0];
        r_size  <= w_win ? bus.s_arsize[5:3] : bus.s_arsize[2:0];
        r_burst <= w_win ? bus.s_arburst[3:2] : bus.s_arburst[1:0];
      end
      if (w_acc)
        r_beat_cnt <= '0;
      if (w_beat)
        r_beat_cnt <= r_beat_cnt + 8'd1;
      if (w_beat & bus.m_axi_rlast)
        r_last_grant <= r_owner;
      // rlast must coincide exactly with the beat numbered arlen
      if (w_beat & ((bus.m_axi_rid != r_id) | (bus.m_axi_rlast != (r_beat_cnt == r_len))))
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
  localparam int IW = 13;
  localparam int AW = 64;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic perr;
  int n_chk = 0;
  int n_err = 0;
  logic [AW-1:0] addr [2];
  logic [IW-1:0] id [2];
  logic [2:0] size [2];
  logic [1:0] burst [2];
  always #5 clk = ~clk;
  axi_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .protocol_err(perr)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr_r;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rid    = '0;
    bus.m_axi_rdata  = '0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.s_arvalid = 2'b00;
    bus.m_axi_arready = 1'b0;
    clr_r();
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic xact(input logic [1:0] req, input bit own, input logic [7:0] len, input int ar_wait,
                      input int last_at, input logic [IW-1:0] rid_x, input int stall_at);
    logic [1:0] oh;
    oh = own ? 2'b10 : 2'b01;
    bus.s_arlen = {len, len};
    bus.s_arvalid = req;
    #1;
    chk("idle_arvalid", bus.m_axi_arvalid, 0);
    chk("idle_arready", bus.s_arready, 0);
    tick();
    for (int w = 0; w <= ar_wait; w++) begin
      bus.m_axi_arready = (w == ar_wait);
      #1;
      chk("arvalid", bus.m_axi_arvalid, 1);
      chk("araddr", bus.m_axi_araddr, addr[own]);
      chk("arid", bus.m_axi_arid, id[own]);
      chk("arlen", bus.m_axi_arlen, len);
      chk("arsize", bus.m_axi_arsize, size[own]);
      chk("arburst", bus.m_axi_arburst, burst[own]);
      chk("s_arready", bus.s_arready, (w == ar_wait) ? oh : 2'b00);
      tick();
    end
    bus.m_axi_arready = 1'b0;
    bus.s_arvalid = req & ~oh;
    for (int i = 0; i <= last_at; i++) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rid    = id[own] ^ rid_x;
      bus.m_axi_rlast  = (i == last_at);
      bus.m_axi_rdata  = {32'hbeef0000, 32'(i)};
      if (i == stall_at) begin
        bus.s_rready = ~oh;
        #1;
        chk("stall_rready", bus.m_axi_rready, 0);
        tick();
        chk("stall_cnt", dut.r_beat_cnt, i);
        bus.s_rready = 2'b11;
      end
      #1;
      chk("s_rvalid", bus.s_rvalid, oh);
      chk("m_rready", bus.m_axi_rready, 1);
      chk("rdata", bus.s_rdata, {32'hbeef0000, 32'(i)});
      chk("rlast", bus.s_rlast, i == last_at);
      tick();
    end
    clr_r();
    #1;
    chk("end_arvalid", bus.m_axi_arvalid, 0);
    chk("end_rvalid", bus.s_rvalid, 0);
    chk("end_cnt", dut.r_beat_cnt, last_at + 1);
  endtask
  initial begin
    addr[0] = 64'h1000;            addr[1] = 64'h2000_0000_0000_0040;
    id[0]   = 13'h005;             id[1]   = 13'h1a3;
    size[0] = 3'd3;                size[1] = 3'd2;
    burst[0] = 2'd1;               burst[1] = 2'd2;
    bus.s_araddr  = {addr[1], addr[0]};
    bus.s_arid    = {id[1], id[0]};
    bus.s_arsize  = {size[1], size[0]};
    bus.s_arburst = {burst[1], burst[0]};
    bus.s_arlen   = '0;
    bus.s_rready  = 2'b11;
    bus.m_axi_rresp = 2'b00;
    do_reset();
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_araddr", bus.m_axi_araddr, 0);
    chk("rst_s_arready", bus.s_arready, 0);
    chk("rst_s_rvalid", bus.s_rvalid, 0);
    chk("rst_m_rready", bus.m_axi_rready, 0);
    chk("rst_perr", perr, 0);
    xact(2'b01, 1'b0, 8'd7, 0, 7, '0, -1);
    chk("t1_perr", perr, 0);
    do_reset();
    for (int r = 0; r < 6; r++)
      xact(2'b11, r[0], 8'd3, 0, 3, '0, -1);
    xact(2'b01, 1'b0, 8'd2, 5, 2, '0, -1);
    xact(2'b10, 1'b1, 8'd7, 0, 7, '0, 3);
    chk("stall_perr", perr, 0);
    xact(2'b01, 1'b0, 8'd7, 0, 4, '0, -1);
    chk("early_last_perr", perr, 1);
    xact(2'b10, 1'b1, 8'd1, 0, 1, '0, -1);
    chk("sticky_perr", perr, 1);
    do_reset();
    chk("rst2_perr", perr, 0);
    xact(2'b01, 1'b0, 8'd3, 0, 3, 13'h001, -1);
    chk("bad_rid_perr", perr, 1);
    do_reset();
    bus.s_arlen = {8'd7, 8'd7};
    bus.s_arvalid = 2'b01;
    tick();
    bus.m_axi_arready = 1'b1;
    tick();
    bus.m_axi_arready = 1'b0;
    bus.s_arvalid = 2'b00;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rid = id[0];
    tick();
    tick();
    tick();
    chk("mid_cnt", dut.r_beat_cnt, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_s_rvalid", bus.s_rvalid, 0);
    chk("mr_m_rready", bus.m_axi_rready, 0);
    chk("mr_arvalid", bus.m_axi_arvalid, 0);
    chk("mr_araddr", bus.m_axi_araddr, 0);
    chk("mr_rdata", bus.s_rdata, 0);
    chk("mr_perr", perr, 0);
    clr_r();
    tick();
    xact(2'b01, 1'b0, 8'd7, 0, 7, '0, -1);
    chk("final_perr", perr, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
